sdram_sim: RTL and testbench

- Cycle-approximate behavioural model of the board SDRAM, used in simulation in place of MemoryController.
- Presents a 32-bit word-addressed read/write/refresh port with a busy handshake to the DRAM front-end (DRAM_conRV) when SIM_TNSRAM is set.
- Storage is a byte array that the simulation loader preloads hierarchically before reset is released.

---
 rtl/sdram_sim_pkg.sv | 17 +
 rtl/sdram_sim_if.sv | 22 ++
 rtl/sdram_sim_store.sv | 40 ++++
 rtl/sdram_sim.sv | 109 ++++++++++
 tb/tb_sdram_sim.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sdram_sim_pkg.sv
// Shared defaults and FSM encoding for the behavioural SDRAM model.
package sdram_sim_pkg;

  localparam int MEM_SIZE_DEF    = 1048576;
  localparam int READ_LAT_DEF    = 4;
  localparam int WRITE_LAT_DEF   = 4;
  localparam int REFRESH_LAT_DEF = 8;

  // Wide enough for any sensible latency setting
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/sdram_sim_if.sv
// Word-addressed read/write/refresh port with busy handshake.
interface sdram_sim_if;
  logic [31:0] w_addr;
  logic        w_le;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic        w_refresh;
  logic [31:0] w_mtime;
  logic [31:0] w_odata;
  logic        w_stall;

  modport master (
    output w_addr, w_le, w_we, w_wdata, w_mask, w_refresh, w_mtime,
    input  w_odata, w_stall
  );

  modport slave (
    input  w_addr, w_le, w_we, w_wdata, w_mask, w_refresh, w_mtime,
    output w_odata, w_stall
  );
endinterface

// File: rtl/sdram_sim_store.sv
// Byte array storage: combinational word read, masked word write.
// The array is reachable by the loader as <inst>.idbmem.mem[j]; it is never
// cleared by reset so preloaded content survives.
module sdram_sim_store
  import sdram_sim_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic        clk_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] rdata_o
);

  localparam int AW = $clog2(MEM_SIZE);

  logic [7:0]    mem [0:MEM_SIZE-1];
  logic [AW-3:0] widx;
  logic          unused_addr;

  // Out-of-range addresses wrap; the byte offset bits are ignored
  assign widx        = addr_i[AW-1:2];
  assign unused_addr = ^{addr_i[31:AW], addr_i[1:0]};

  // Little-endian word assembly
  assign rdata_o = {mem[{widx, 2'd3}], mem[{widx, 2'd2}],
                    mem[{widx, 2'd1}], mem[{widx, 2'd0}]};

  // Commit enabled bytes on the acceptance edge
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_i[i]) mem[{widx, 2'(i)}] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sdram_sim.sv
// Cycle-approximate SDRAM stand-in: idle/busy FSM with a down-counter
// that models per-operation latency in front of a byte array store.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | w_stall=0, accepts one request (we > le > refresh)
// ST_BUSY | w_stall=1, counter running, all requests ignored
module sdram_sim
  import sdram_sim_pkg::*;
#(
  parameter int MEM_SIZE    = MEM_SIZE_DEF,
  parameter int READ_LAT    = READ_LAT_DEF,
  parameter int WRITE_LAT   = WRITE_LAT_DEF,
  parameter int REFRESH_LAT = REFRESH_LAT_DEF
) (
  input logic         CLK,
  input logic         RST,
  sdram_sim_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic [31:0]      odata_q, odata_d;
  logic [31:0]      rdword_q, rdword_d;
  logic             is_rd_q, is_rd_d;
  logic             st_we;
  logic [31:0]      st_rdata;
  logic             unused_mtime;

  // w_mtime only matters for debug tracing
  assign unused_mtime = ^bus.w_mtime;

  sdram_sim_store #(.MEM_SIZE(MEM_SIZE)) idbmem (
    .clk_i   (CLK),
    .addr_i  (bus.w_addr),
    .we_i    (st_we && !RST),
    .wdata_i (bus.w_wdata),
    .mask_i  (bus.w_mask),
    .rdata_o (st_rdata)
  );

  // Next-state: accept one request when idle, count down when busy
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    odata_d  = odata_q;
    rdword_d = rdword_q;
    is_rd_d  = is_rd_q;
    st_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.w_we) begin
          st_we   = 1'b1;
          cnt_d   = CNT_W'(WRITE_LAT);
          is_rd_d = 1'b0;
          state_d = ST_BUSY;
          stall_d = 1'b1;
        end else if (bus.w_le) begin
          rdword_d = st_rdata;
          cnt_d    = CNT_W'(READ_LAT);
          is_rd_d  = 1'b1;
          state_d  = ST_BUSY;
          stall_d  = 1'b1;
        end else if (bus.w_refresh) begin
          cnt_d   = CNT_W'(REFRESH_LAT);
          is_rd_d = 1'b0;
          state_d = ST_BUSY;
          stall_d = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          // Data and stall release land on the same edge
          cnt_d   = '0;
          state_d = ST_IDLE;
          stall_d = 1'b0;
          if (is_rd_q) odata_d = rdword_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      odata_q  <= '0;
      rdword_q <= '0;
      is_rd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      odata_q  <= odata_d;
      rdword_q <= rdword_d;
      is_rd_q  <= is_rd_d;
    end
  end

  assign bus.w_odata = odata_q;
  assign bus.w_stall = stall_q;

endmodule

// File: tb/tb_sdram_sim.sv
// Directed bench for sdram_sim: word model plus a queue of expected read data.
module tb_sdram_sim;

  localparam int MEM  = 1048576;
  localparam int RLAT = 4;
  localparam int WLAT = 4;
  localparam int FLAT = 8;

  localparam int OP_WR   = 0;
  localparam int OP_RD   = 1;
  localparam int OP_REF  = 2;
  localparam int OP_WRRD = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [int];
  logic [31:0] sb_q [$];
  logic [31:0] last_odata = '0;

  sdram_sim_if bus ();

  sdram_sim #(
    .MEM_SIZE(MEM), .READ_LAT(RLAT), .WRITE_LAT(WLAT), .REFRESH_LAT(FLAT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a % MEM) >> 2);
  endfunction

  function automatic logic [31:0] mdl_get(input logic [31:0] a);
    if (mdl.exists(widx(a))) return mdl[widx(a)];
    return 32'h0;
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] m);
    logic [31:0] w;
    w = mdl_get(a);
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[widx(a)] = w;
  endfunction

  // intr: 0 none, 1 hold a write to 0x300 while busy, 2 hold a read while busy
  task automatic run_op(input string tag, input int kind, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input int intr);
    int n;
    int lat;
    @(negedge CLK);
    bus.w_addr    = addr;
    bus.w_wdata   = data;
    bus.w_mask    = mask;
    bus.w_we      = (kind == OP_WR || kind == OP_WRRD);
    bus.w_le      = (kind == OP_RD || kind == OP_WRRD);
    bus.w_refresh = (kind == OP_REF);
    case (kind)
      OP_RD:   begin lat = RLAT; sb_q.push_back(mdl_get(addr)); end
      OP_REF:  lat = FLAT;
      default: begin lat = WLAT; mdl_write(addr, data, mask); end
    endcase
    @(negedge CLK);
    bus.w_we = 1'b0; bus.w_le = 1'b0; bus.w_refresh = 1'b0;
    if (intr == 1) begin
      bus.w_we = 1'b1; bus.w_addr = 32'h300; bus.w_wdata = 32'h0; bus.w_mask = 4'hF;
    end else if (intr == 2) begin
      bus.w_le = 1'b1; bus.w_addr = 32'h100;
    end
    n = 0;
    while (bus.w_stall === 1'b1 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    bus.w_we = 1'b0; bus.w_le = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat));
    if (kind == OP_RD) begin
      if (sb_q.size() > 0) last_odata = sb_q.pop_front();
      check({tag, "_data"}, bus.w_odata, last_odata);
    end else begin
      check({tag, "_odata_hold"}, bus.w_odata, last_odata);
    end
  endtask

  initial begin
    dut.idbmem.mem[0] = 8'hAA;
    mdl[0] = 32'h0000_00AA;
    bus.w_addr = '0; bus.w_wdata = '0; bus.w_mask = '0; bus.w_mtime = '0;
    bus.w_we = 1'b0; bus.w_refresh = 1'b0;
    bus.w_le = 1'b1;

    // reset held with a read request pending
    @(negedge CLK);
    @(negedge CLK);
    check("rst_stall", {31'b0, bus.w_stall}, 32'h0);
    check("rst_odata", bus.w_odata, 32'h0);
    RST = 1'b0;
    bus.w_le = 1'b0;

    run_op("preload", OP_RD, 32'h0, 32'h0, 4'h0, 0);

    run_op("wr100", OP_WR, 32'h100, 32'hDEADBEEF, 4'hF, 0);
    run_op("rd100", OP_RD, 32'h100, 32'h0, 4'h0, 0);

    run_op("wr200", OP_WR, 32'h200, 32'h11223344, 4'hF, 0);
    run_op("wr200p", OP_WR, 32'h200, 32'hAABBCCDD, 4'b0110, 0);
    run_op("rd202", OP_RD, 32'h202, 32'h0, 4'h0, 0);

    run_op("wr100m0", OP_WR, 32'h100, 32'h01020304, 4'h0, 0);
    run_op("rd100m0", OP_RD, 32'h100, 32'h0, 4'h0, 0);

    run_op("wr300", OP_WR, 32'h300, 32'hCAFEF00D, 4'hF, 0);
    run_op("rd_blk", OP_RD, 32'h200, 32'h0, 4'h0, 1);
    run_op("rd300", OP_RD, 32'h300, 32'h0, 4'h0, 0);

    run_op("wrrd400", OP_WRRD, 32'h400, 32'h55667788, 4'hF, 0);
    run_op("rd400", OP_RD, 32'h400, 32'h0, 4'h0, 0);

    run_op("refresh", OP_REF, 32'h0, 32'h0, 4'h0, 2);
    run_op("rd100b", OP_RD, 32'h100, 32'h0, 4'h0, 0);
    run_op("rd400b", OP_RD, 32'h400, 32'h0, 4'h0, 0);

    run_op("wrwrap", OP_WR, MEM + 32'h10, 32'h12345678, 4'hF, 0);
    run_op("rd010", OP_RD, 32'h10, 32'h0, 4'h0, 0);

    // reset in the middle of a read's busy window
    @(negedge CLK);
    bus.w_addr = 32'h100;
    bus.w_le = 1'b1;
    @(negedge CLK);
    bus.w_le = 1'b0;
    check("midrst_busy", {31'b0, bus.w_stall}, 32'h1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_stall", {31'b0, bus.w_stall}, 32'h0);
    check("midrst_odata", bus.w_odata, 32'h0);
    RST = 1'b0;
    last_odata = 32'h0;
    run_op("rd_after_rst", OP_RD, 32'h10, 32'h0, 4'h0, 0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
